// File: rtl/icache_direct_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Frame layout, controller states and the default geometry live here.
package icache_direct_pkg;

   localparam int ICACHE_SETS  = 16;
   localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
   localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   typedef struct packed {
      logic                    valid;
      logic [ICACHE_TAG_W-1:0] tag;
      logic [31:0]             data;
   } icachef_t;

   // Instruction fetches are word granular; byte offset bits carry no meaning.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Register-based frame store: SETS x {valid, tag, data}, one combinational
// read port, one write port, valid bits cleared asynchronously.
module icache_frame_array
   import icache_direct_pkg::*;
#(
   parameter int SETS  = ICACHE_SETS,
   parameter int IDX_W = $clog2(SETS),
   parameter int TAG_W = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] ridx,
   output logic             rvalid,
   output logic [TAG_W-1:0] rtag,
   output logic [31:0]      rdata,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [TAG_W-1:0] wtag,
   input  logic [31:0]      wdata
);

   logic [SETS-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [TAG_W-1:0] tag_d  [SETS];
   logic [31:0]      data_q [SETS];
   logic [31:0]      data_d [SETS];

   assign rvalid = valid_q[ridx];
   assign rtag   = tag_q[ridx];
   assign rdata  = data_q[ridx];

   // Next-state of the frame store: a write replaces the whole frame.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (we) begin
         valid_d[widx] = 1'b1;
         tag_d[widx]   = wtag;
         data_d[widx]  = wdata;
      end else begin
         valid_d = valid_q;
      end
   end

   // Frame storage with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < SETS; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= 32'h0000_0000;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block, read-only instruction cache between the
// fetch port and the memory controller; same-cycle hits, single-word fills.
module icache_direct
   import icache_direct_pkg::*;
#(
   parameter int SETS = ICACHE_SETS
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic [31:0] imemload,
   output logic        ihit,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic [31:0] iload,
   input  logic        iwait
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   icache_state_t state_q, state_d;
   logic [31:0]   miss_addr_q, miss_addr_d;

   logic [IDX_W-1:0] req_idx_s, miss_idx_s;
   logic [TAG_W-1:0] req_tag_s, miss_tag_s;
   logic             frame_valid_s;
   logic [TAG_W-1:0] frame_tag_s;
   logic [31:0]      frame_data_s;
   logic             lookup_hit_s;
   logic             fill_done_s;
   logic             fwd_match_s;

   assign req_idx_s  = imemaddr[IDX_W+1:2];
   assign req_tag_s  = imemaddr[31:IDX_W+2];
   assign miss_idx_s = miss_addr_q[IDX_W+1:2];
   assign miss_tag_s = miss_addr_q[31:IDX_W+2];

   assign lookup_hit_s = frame_valid_s && (frame_tag_s == req_tag_s);
   assign fill_done_s  = (state_q == FILL) && !iwait;
   assign fwd_match_s  = (imemaddr[31:2] == miss_addr_q[31:2]);

   icache_frame_array #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_frames (
      .clk    (CLK),
      .rst    (RST),
      .ridx   (req_idx_s),
      .rvalid (frame_valid_s),
      .rtag   (frame_tag_s),
      .rdata  (frame_data_s),
      .we     (fill_done_s),
      .widx   (miss_idx_s),
      .wtag   (miss_tag_s),
      .wdata  (iload)
   );

   // Controller state and captured miss address.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         miss_addr_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
      end
   end

   // Next state: a miss starts a fill, the fill always runs to completion.
   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      case (state_q)
         IDLE: begin
            if (imemREN && !lookup_hit_s) begin
               state_d     = FILL;
               miss_addr_d = word_align(imemaddr);
            end else begin
               state_d = IDLE;
            end
         end
         FILL: begin
            if (!iwait) begin
               state_d = IDLE;
            end else begin
               state_d = FILL;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: hit/forward mux and fill request; imemload is forced to zero without a hit.
   always_comb begin
      ihit     = 1'b0;
      imemload = 32'h0000_0000;
      iREN     = 1'b0;
      iaddr    = 32'h0000_0000;
      if (RST) begin
         ihit = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (imemREN && lookup_hit_s) begin
                  ihit     = 1'b1;
                  imemload = frame_data_s;
               end else begin
                  ihit = 1'b0;
               end
            end
            FILL: begin
               iREN  = 1'b1;
               iaddr = miss_addr_q;
               if (!iwait && imemREN && fwd_match_s) begin
                  ihit     = 1'b1;
                  imemload = iload;
               end else begin
                  ihit = 1'b0;
               end
            end
            default: begin
               ihit = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: stimulus pushes expected hit data into a
// scoreboard queue, a negedge monitor pops and compares on every ihit.
module tb_icache_direct;

   logic        CLK;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        ihit;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;

   int          checks;
   int          errors;
   logic [31:0] exp_q [$];

   icache_direct #(.SETS(16)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .imemload (imemload),
      .ihit     (ihit),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .iwait    (iwait)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every hit must match the oldest expected word.
   always @(negedge CLK) begin
      if (!RST && ihit === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_hit: got ihit=1 data %h expected ihit=0", imemload);
         end else begin
            chk("hit_data", imemload, exp_q.pop_front());
         end
      end
   end

   // One fetch cycle: drive inputs, compare fill-side outputs and miss behaviour.
   task automatic cyc(input logic ren, input logic [31:0] addr, input logic wt,
                      input logic [31:0] ld, input logic exp_hit, input logic [31:0] exp_data,
                      input logic exp_iren, input logic [31:0] exp_iaddr, input string tag);
      imemREN  = ren;
      imemaddr = addr;
      iwait    = wt;
      iload    = ld;
      if (exp_hit) exp_q.push_back(exp_data);
      @(negedge CLK);
      chk({tag, ".iREN"}, {31'd0, iREN}, {31'd0, exp_iren});
      chk({tag, ".iaddr"}, iaddr, exp_iaddr);
      if (!exp_hit) begin
         chk({tag, ".ihit"}, {31'd0, ihit}, 32'd0);
         chk({tag, ".imemload"}, imemload, 32'd0);
      end else begin
         #2;
         chk({tag, ".hit_seen"}, exp_q.size(), 32'd0);
         exp_q.delete();
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      repeat (2000) @(posedge CLK);
      $display("FAIL watchdog: got no completion expected finish within 2000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      RST      = 1'b1;
      imemREN  = 1'b1;
      imemaddr = 32'h0;
      iwait    = 1'b0;
      iload    = 32'h0;
      #3;
      chk("rst.ihit", {31'd0, ihit}, 32'd0);
      chk("rst.iREN", {31'd0, iREN}, 32'd0);
      chk("rst.iaddr", iaddr, 32'd0);
      chk("rst.imemload", imemload, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // Cold miss on 0x0, two wait cycles, then hit from the cache.
      cyc(1'b1, 32'h0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0, "cold_c0");
      cyc(1'b1, 32'h0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0, "cold_c1");
      cyc(1'b1, 32'h0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0, "cold_c2");
      cyc(1'b1, 32'h0, 1'b0, 32'h2008000A, 1'b1, 32'h2008000A, 1'b1, 32'h0, "cold_c3");
      cyc(1'b1, 32'h0, 1'b1, 32'hBADBAD00, 1'b1, 32'h2008000A, 1'b0, 32'h0, "refetch");

      // Idle gating with a cached address, then confirm nothing changed.
      cyc(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0,        1'b0, 32'h0, "gate0");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 32'h0, "gate1");
      cyc(1'b1, 32'h3, 1'b1, 32'h0, 1'b1, 32'h2008000A, 1'b0, 32'h0, "gate_hit");

      // Conflict eviction at index 0 with minimum miss penalty.
      cyc(1'b1, 32'h40, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "evict_miss");
      cyc(1'b1, 32'h40, 1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 32'h40, "evict_fill");
      cyc(1'b1, 32'h40, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0,  "evict_hit");
      cyc(1'b1, 32'h0,  1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "remiss");
      cyc(1'b1, 32'h0,  1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,  "remiss_fill");
      cyc(1'b1, 32'h0,  1'b0, 32'h2008000A, 1'b1, 32'h2008000A, 1'b1, 32'h0,  "remiss_done");

      // Redirect mid-fill: fill of 0x10 completes silently, 0x80 then misses.
      cyc(1'b1, 32'h10, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "redir_miss");
      cyc(1'b1, 32'h80, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h10, "redir_wait");
      cyc(1'b1, 32'h80, 1'b0, 32'h11111111, 1'b0, 32'h0,        1'b1, 32'h10, "redir_done");
      cyc(1'b1, 32'h80, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "redir_new");
      cyc(1'b1, 32'h80, 1'b0, 32'h22222222, 1'b1, 32'h22222222, 1'b1, 32'h80, "redir_fill");
      cyc(1'b1, 32'h10, 1'b1, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0,  "redir_kept");

      // imemREN dropping during a fill still installs the frame.
      cyc(1'b1, 32'h20, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "drop_miss");
      cyc(1'b0, 32'h20, 1'b0, 32'h33333333, 1'b0, 32'h0,        1'b1, 32'h20, "drop_fill");
      cyc(1'b1, 32'h20, 1'b1, 32'h0,        1'b1, 32'h33333333, 1'b0, 32'h0,  "drop_hit");

      // Reset mid-fill: request drops at once, cache comes back empty.
      cyc(1'b1, 32'h44, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,  "rstf_miss");
      cyc(1'b1, 32'h44, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h44, "rstf_wait");
      RST = 1'b1;
      #1;
      chk("rstf.iREN", {31'd0, iREN}, 32'd0);
      chk("rstf.ihit", {31'd0, ihit}, 32'd0);
      chk("rstf.iaddr", iaddr, 32'd0);
      chk("rstf.imemload", imemload, 32'd0);
      iwait = 1'b0;
      iload = 32'h44444444;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      cyc(1'b1, 32'h0,  1'b1, 32'h0,        1'b0, 32'h0, 1'b0, 32'h0, "post_rst_miss");
      cyc(1'b1, 32'h0,  1'b1, 32'h0,        1'b0, 32'h0, 1'b1, 32'h0, "post_rst_fill");
      cyc(1'b1, 32'h44, 1'b0, 32'h55555555, 1'b0, 32'h0, 1'b1, 32'h0, "post_rst_done");
      cyc(1'b1, 32'h44, 1'b1, 32'h0,        1'b0, 32'h0, 1'b0, 32'h0, "late_load_ignored");

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
